// File: rtl/mult_share_arb.sv
// mult_share_arb
// Shares one pipelined multiplier between NUM_REQ requester streams.
// Requests are picked round-robin, tagged with the requester id in the MSBs
// of the multiplier ctl word, and issued through a single output register.
// Products come back in any interleaving. The tag steers each product into
// a one-entry response slot owned by that requester. An outstanding counter
// limits the number of requests in flight. The limit counts requests already
// inside the multiplier plus the one staged in the issue register.
module mult_share_arb #(
  parameter int NUM_REQ  = 2,
  parameter int DAT_BITS = 512,
  parameter int CTL_BITS = 8,
  parameter int MAX_OUT  = 16,
  localparam int ID_BITS  = $clog2(NUM_REQ),
  localparam int CNT_BITS = $clog2(MAX_OUT + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  // requester side
  input  logic [NUM_REQ*DAT_BITS-1:0]    i_req_dat,
  input  logic [NUM_REQ*CTL_BITS-1:0]    i_req_ctl,
  input  logic [NUM_REQ-1:0]             i_req_val,
  output logic [NUM_REQ-1:0]             o_req_rdy,
  // multiplier request side
  output logic [DAT_BITS-1:0]            o_mul_dat,
  output logic [CTL_BITS+ID_BITS-1:0]    o_mul_ctl,
  output logic                           o_mul_val,
  input  logic                           i_mul_rdy,
  // multiplier response side
  input  logic [DAT_BITS-1:0]            i_mul_dat,
  input  logic [CTL_BITS+ID_BITS-1:0]    i_mul_ctl,
  input  logic                           i_mul_val,
  output logic                           o_mul_rdy,
  // per-requester responses
  output logic [NUM_REQ*DAT_BITS-1:0]    o_rsp_dat,
  output logic [NUM_REQ*CTL_BITS-1:0]    o_rsp_ctl,
  output logic [NUM_REQ-1:0]             o_rsp_val,
  input  logic [NUM_REQ-1:0]             i_rsp_rdy,
  output logic                           o_err
);

  // Round-robin successor: wraps at NUM_REQ, which need not be a power of two.
  function automatic logic [ID_BITS-1:0] nxt_id(input logic [ID_BITS-1:0] id);
    if (id == ID_BITS'(NUM_REQ - 1)) begin
      return '0;
    end
    return id + ID_BITS'(1);
  endfunction

  localparam logic [CNT_BITS:0] MAX_CNT = (CNT_BITS + 1)'(MAX_OUT);

  // arbitration state and combinational grant
  logic [ID_BITS-1:0]          ptr_p0;
  logic [ID_BITS-1:0]          cand_p0;
  logic [ID_BITS-1:0]          gnt_id_p0;
  logic                        gnt_any_p0;
  logic                        slot_free_p0;
  logic                        cap_ok_p0;
  logic                        gnt_p0;
  logic [CNT_BITS:0]           pend_p0;

  // issue register toward the multiplier
  logic [DAT_BITS-1:0]         mul_dat_p1;
  logic [CTL_BITS+ID_BITS-1:0] mul_ctl_p1;
  logic                        mul_val_p1;

  // response steering
  logic [ID_BITS-1:0]          rsp_id;
  logic                        rsp_id_ok;
  logic                        rsp_acc;
  logic                        issue;
  logic                        cnt_dec;
  logic [CNT_BITS-1:0]         cnt;
  logic                        err;

  // per-requester response slots
  logic [DAT_BITS-1:0]         rsp_dat_p1 [NUM_REQ];
  logic [CTL_BITS-1:0]         rsp_ctl_p1 [NUM_REQ];
  logic [NUM_REQ-1:0]          rsp_val_p1;

  // ---- stage p0: arbitration ----

  // Pick the first valid requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_any_p0 = 1'b0;
    gnt_id_p0  = '0;
    cand_p0    = ptr_p0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any_p0 && i_req_val[cand_p0]) begin
        gnt_any_p0 = 1'b1;
        gnt_id_p0  = cand_p0;
      end
      cand_p0 = nxt_id(cand_p0);
    end
  end

  // Response tag decode and backpressure toward the multiplier. An illegal
  // tag is always accepted so the multiplier cannot lock up on it.
  always_comb begin
    rsp_id    = i_mul_ctl[CTL_BITS +: ID_BITS];
    rsp_id_ok = ({1'b0, rsp_id} < (ID_BITS + 1)'(NUM_REQ));
    o_mul_rdy = rsp_id_ok ? (~rsp_val_p1[rsp_id] | i_rsp_rdy[rsp_id]) : 1'b1;
    rsp_acc   = i_mul_val & o_mul_rdy;
    issue     = mul_val_p1 & i_mul_rdy;
    cnt_dec   = rsp_acc & (cnt != '0);
  end

  // Grant gating. The staged request in the issue register counts toward
  // the in-flight limit, so at most MAX_OUT requests are ever committed. A
  // response retired this cycle frees one place immediately.
  always_comb begin
    slot_free_p0 = ~mul_val_p1 | i_mul_rdy;
    pend_p0      = {1'b0, cnt} + {{CNT_BITS{1'b0}}, mul_val_p1};
    cap_ok_p0    = (pend_p0 < MAX_CNT) | rsp_acc;
    gnt_p0       = gnt_any_p0 & slot_free_p0 & cap_ok_p0;
    o_req_rdy    = '0;
    if (gnt_p0) begin
      o_req_rdy[gnt_id_p0] = 1'b1;
    end
  end

  // ---- stage p1: issue register, response slots, bookkeeping ----

  // Control state: pointer, valids, outstanding count and sticky error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_p0     <= '0;
      mul_val_p1 <= 1'b0;
      rsp_val_p1 <= '0;
      cnt        <= '0;
      err        <= 1'b0;
    end else begin
      if (gnt_p0) begin
        mul_val_p1 <= 1'b1;
        ptr_p0     <= nxt_id(gnt_id_p0);
      end else if (i_mul_rdy) begin
        mul_val_p1 <= 1'b0;
      end

      for (int n = 0; n < NUM_REQ; n++) begin
        if (rsp_acc && rsp_id_ok && (rsp_id == ID_BITS'(n))) begin
          rsp_val_p1[n] <= 1'b1;
        end else if (i_rsp_rdy[n]) begin
          rsp_val_p1[n] <= 1'b0;
        end
      end

      if (issue && !cnt_dec) begin
        cnt <= cnt + CNT_BITS'(1);
      end else if (!issue && cnt_dec) begin
        cnt <= cnt - CNT_BITS'(1);
      end

      if (rsp_acc && ((cnt == '0) || !rsp_id_ok)) begin
        err <= 1'b1;
      end
    end
  end

  // Data payloads: loaded on grant or response accept, otherwise held.
  always_ff @(posedge i_clk) begin
    if (gnt_p0) begin
      for (int n = 0; n < NUM_REQ; n++) begin
        if (gnt_id_p0 == ID_BITS'(n)) begin
          mul_dat_p1 <= i_req_dat[n*DAT_BITS +: DAT_BITS];
          mul_ctl_p1 <= {gnt_id_p0, i_req_ctl[n*CTL_BITS +: CTL_BITS]};
        end
      end
    end
    for (int n = 0; n < NUM_REQ; n++) begin
      if (rsp_acc && rsp_id_ok && (rsp_id == ID_BITS'(n))) begin
        rsp_dat_p1[n] <= i_mul_dat;
        rsp_ctl_p1[n] <= i_mul_ctl[CTL_BITS-1:0];
      end
    end
  end

  assign o_mul_dat = mul_dat_p1;
  assign o_mul_ctl = mul_ctl_p1;
  assign o_mul_val = mul_val_p1;
  assign o_rsp_val = rsp_val_p1;
  assign o_err     = err;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    assign o_rsp_dat[g*DAT_BITS +: DAT_BITS] = rsp_dat_p1[g];
    assign o_rsp_ctl[g*CTL_BITS +: CTL_BITS] = rsp_ctl_p1[g];
  end

endmodule
